// File: rtl/if_stage_param_pkg.sv
// Shared constants, state encoding and bubble helper for the instruction-fetch stage.
package if_stage_param_pkg;

  localparam int ADDR_W_DEF      = 64;
  localparam int INSTR_W_DEF     = 32;
  localparam int PC_INC_DEF      = 4;
  localparam int BTB_ENTRIES_DEF = 16;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic valid;
    logic pred_taken;
  } id_flags_t;

  function automatic id_flags_t bubble_flags();
    id_flags_t f;
    f.valid      = 1'b0;
    f.pred_taken = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/if_stage_param_if.sv
// Fetch-stage bus: PC-select inputs, instruction memory port, BTB update and IF/ID outputs.
interface if_stage_param_if
  import if_stage_param_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic [ADDR_W-1:0]  StartPC;
  logic               PCSrc;
  logic [ADDR_W-1:0]  TargetPC;
  logic               stall_IF;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               btb_upd_valid;
  logic [ADDR_W-1:0]  btb_upd_pc;
  logic [ADDR_W-1:0]  btb_upd_target;
  logic               btb_upd_taken;
  logic [INSTR_W-1:0] instruction_ID;
  logic [ADDR_W-1:0]  pc_ID;
  logic               valid_ID;
  logic               pred_taken_ID;

  // Upstream side: PC-select logic, instruction memory and decode.
  modport master (
    output StartPC, PCSrc, TargetPC, stall_IF, imem_rdata,
           btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    input  imem_addr, instruction_ID, pc_ID, valid_ID, pred_taken_ID
  );

  // The fetch stage itself.
  modport slave (
    input  StartPC, PCSrc, TargetPC, stall_IF, imem_rdata,
           btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    output imem_addr, instruction_ID, pc_ID, valid_ID, pred_taken_ID
  );
endinterface

// File: rtl/if_stage_param_btb.sv
// Direct-mapped branch target buffer: combinational lookup, edge-triggered install/invalidate.
module if_stage_param_btb
  import if_stage_param_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ENTRIES = BTB_ENTRIES_DEF
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             unused_low_bits;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  // Instructions are word aligned, so the byte offset never selects an entry.
  assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target_o = target_q[lk_idx];

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
      end else if (tag_q[up_idx] == up_tag) begin
        valid_q[up_idx] <= 1'b0;
      end
    end
  end

  // Tag and target need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC register, imem addressing and IF/ID register with stall/redirect.
// Optional BTB enabled with macro IF_BTB_EN.
module if_stage_param
  import if_stage_param_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int PC_INC      = PC_INC_DEF,
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
  input logic          clk,
  input logic          resetl,
  if_stage_param_if.slave bus
);
  // state   | meaning
  // ST_BOOT | first edge after reset: load StartPC, IF/ID stays a bubble
  // ST_RUN  | normal fetch with redirect > stall > advance priority

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_id_q, pc_id_d;
  id_flags_t          flags_q, flags_d;

  logic               btb_hit;
  logic [ADDR_W-1:0]  btb_target;
  logic [ADDR_W-1:0]  next_pc;

`ifdef IF_BTB_EN
  if_stage_param_btb #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .resetl       (resetl),
    .lookup_pc_i  (pc_q),
    .hit_o        (btb_hit),
    .target_o     (btb_target),
    .upd_valid_i  (bus.btb_upd_valid),
    .upd_pc_i     (bus.btb_upd_pc),
    .upd_target_i (bus.btb_upd_target),
    .upd_taken_i  (bus.btb_upd_taken)
  );
`else
  logic unused_btb_upd;
  assign unused_btb_upd = ^{bus.btb_upd_valid, bus.btb_upd_pc,
                            bus.btb_upd_target, bus.btb_upd_taken};
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  assign next_pc = btb_hit ? btb_target : pc_q + ADDR_W'(PC_INC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    flags_d = flags_q;
    unique case (state_q)
      ST_BOOT: begin
        pc_d    = bus.StartPC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.PCSrc) begin
          // Redirect flushes the wrong-path fetch; pc_ID is intentionally held.
          pc_d    = bus.TargetPC;
          instr_d = INSTR_W'(NOP_INSTR);
          flags_d = bubble_flags();
        end else if (!bus.stall_IF) begin
          pc_d               = next_pc;
          instr_d            = bus.imem_rdata;
          pc_id_d            = pc_q;
          flags_d.valid      = 1'b1;
          flags_d.pred_taken = btb_hit;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      pc_id_q <= '0;
      flags_q <= bubble_flags();
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      flags_q <= flags_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.instruction_ID = instr_q;
  assign bus.pc_ID          = pc_id_q;
  assign bus.valid_ID       = flags_q.valid;
  assign bus.pred_taken_ID  = flags_q.pred_taken;

endmodule
